// File: rtl/uart_rx_fifo_if.sv
// Receive-byte ingress plus consumer-side valid/ready stream and status for uart_rx_fifo.
// master is the FIFO's view; slave is the receiver/consumer view.
interface uart_rx_fifo_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LVL_W  = 5,
  parameter int unsigned CNT_W  = 8
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_done;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic [LVL_W-1:0]  level;
  logic              empty;
  logic              full;
  logic              overflow;
  logic [CNT_W-1:0]  drop_count;
  logic              overflow_clr;

  modport master (
    input  rx_data, rx_done, m_ready, overflow_clr,
    output m_data, m_valid, level, empty, full, overflow, drop_count
  );

  modport slave (
    output rx_data, rx_done, m_ready, overflow_clr,
    input  m_data, m_valid, level, empty, full, overflow, drop_count
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular byte FIFO behind the UART receiver: edge-detected writes, show-ahead reads,
// level-derived full/empty, sticky overflow with saturating drop counter.
module uart_rx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input logic            clk,
  input logic            rst,
  uart_rx_fifo_if.master bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              rx_done_q, rx_done_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  drop_count_q, drop_count_d;

  logic push_req, pop, push, drop, is_empty, is_full;

  assign is_empty = (level_q == '0);
  assign is_full  = (level_q == LVL_W'(DEPTH));
  assign push_req = bus.rx_done & ~rx_done_q;
  assign pop      = ~is_empty & bus.m_ready;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push     = push_req & (~is_full | pop);
  assign drop     = push_req & is_full & ~pop;

  always_comb begin
    rx_done_d    = bus.rx_done;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    level_d      = level_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;

    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // A drop in the clearing cycle is counted fresh rather than cleared away.
    if (drop) begin
      overflow_d = 1'b1;
      if (bus.overflow_clr)        drop_count_d = CNT_W'(1);
      else if (drop_count_q != '1) drop_count_d = drop_count_q + CNT_W'(1);
    end else if (bus.overflow_clr) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_done_q    <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      rx_done_q    <= rx_done_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.rx_data;
  end

  assign bus.m_data     = is_empty ? '0 : mem_q[rd_ptr_q];
  assign bus.m_valid    = ~is_empty;
  assign bus.level      = level_q;
  assign bus.empty      = is_empty;
  assign bus.full       = is_full;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_count_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DATA_W(8), .LVL_W(5), .CNT_W(8)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0] q[$];
  bit         m_ovf;
  int         m_dcnt;
  bit         m_prev_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf       = 1'b0;
    m_dcnt      = 0;
    m_prev_done = 1'b0;
  endtask

  task automatic check_outputs(input string where);
    chk({where, ":m_valid"},    32'(bus.m_valid),    32'(q.size() != 0));
    chk({where, ":m_data"},     32'(bus.m_data),     (q.size() != 0) ? 32'(q[0]) : 32'd0);
    chk({where, ":level"},      32'(bus.level),      32'(q.size()));
    chk({where, ":empty"},      32'(bus.empty),      32'(q.size() == 0));
    chk({where, ":full"},       32'(bus.full),       32'(q.size() == DEPTH));
    chk({where, ":overflow"},   32'(bus.overflow),   32'(m_ovf));
    chk({where, ":drop_count"}, 32'(bus.drop_count), 32'(m_dcnt));
  endtask

  task automatic model_step(input logic d, input logic [7:0] data, input logic rdy, input logic clr);
    bit req, popped, was_full;
    req      = d && !m_prev_done;
    popped   = (q.size() != 0) && rdy;
    was_full = (q.size() == DEPTH);
    if (popped) void'(q.pop_front());
    if (req && (!was_full || popped)) begin
      q.push_back(data);
    end else if (req) begin
      m_ovf  = 1'b1;
      m_dcnt = clr ? 1 : ((m_dcnt < 255) ? m_dcnt + 1 : 255);
    end
    if (!(req && was_full && !popped) && clr) begin
      m_ovf  = 1'b0;
      m_dcnt = 0;
    end
    m_prev_done = d;
  endtask

  // Starts and ends at a negedge; outputs are checked mid-low-phase before the edge.
  task automatic cycle(input string where, input logic d, input logic [7:0] data,
                       input logic rdy, input logic clr);
    bus.rx_done      = d;
    bus.rx_data      = data;
    bus.m_ready      = rdy;
    bus.overflow_clr = clr;
    #1;
    check_outputs(where);
    @(posedge clk);
    model_step(d, data, rdy, clr);
    @(negedge clk);
  endtask

  task automatic push_byte(input string where, input logic [7:0] data, input logic rdy);
    cycle(where, 1'b1, data, rdy, 1'b0);
    cycle(where, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    bus.rx_done      = 1'b0;
    bus.rx_data      = 8'h00;
    bus.m_ready      = 1'b0;
    bus.overflow_clr = 1'b0;
    model_reset();
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single byte
    cycle("single_push", 1'b1, 8'hA5, 1'b0, 1'b0);
    chk("single_data", 32'(bus.m_data), 32'hA5);
    cycle("single_idle", 1'b0, 8'h00, 1'b0, 1'b0);
    cycle("single_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("single_empty", 32'(bus.empty), 32'd1);

    // Long strobe yields exactly one write
    for (int i = 0; i < 3; i++) cycle("long", 1'b1, 8'h3C, 1'b0, 1'b0);
    cycle("long_lo", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("long_level", 32'(bus.level), 32'd1);
    push_byte("second", 8'h5A, 1'b0);
    chk("second_level", 32'(bus.level), 32'd2);
    cycle("pop_3c", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("pop_5a", 1'b0, 8'h00, 1'b1, 1'b0);

    // Fill then overflow
    for (int i = 0; i < DEPTH; i++) push_byte("fill", 8'(i), 1'b0);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_level", 32'(bus.level), 32'd16);
    push_byte("drop10", 8'h10, 1'b0);
    push_byte("drop11", 8'h11, 1'b0);
    chk("ovf_count", 32'(bus.drop_count), 32'd2);
    chk("ovf_level", 32'(bus.level), 32'd16);
    for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // Clear without a drop
    cycle("clr", 1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovf", 32'(bus.overflow), 32'd0);

    // Full with simultaneous push+pop
    for (int i = 0; i < DEPTH; i++) push_byte("fill2", 8'(8'h40 + i), 1'b0);
    cycle("pushpop", 1'b1, 8'h77, 1'b1, 1'b0);
    cycle("pushpop_lo", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("pushpop_level", 32'(bus.level), 32'd16);
    chk("pushpop_nodrop", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) cycle("drain2", 1'b0, 8'h00, 1'b1, 1'b0);

    // Clear in the same cycle as a drop, then saturate
    for (int i = 0; i < DEPTH; i++) push_byte("fill3", 8'(8'h80 + i), 1'b0);
    push_byte("pre_drop", 8'h98, 1'b0);
    cycle("clr_drop", 1'b1, 8'h99, 1'b0, 1'b1);
    cycle("clr_drop_lo", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("clr_drop_ovf", 32'(bus.overflow), 32'd1);
    chk("clr_drop_cnt", 32'(bus.drop_count), 32'd1);
    for (int i = 0; i < 300; i++) push_byte("sat", 8'($urandom), 1'b0);
    chk("sat_cnt", 32'(bus.drop_count), 32'd255);
    cycle("clr2", 1'b0, 8'h00, 1'b0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic d, rdy, clr;
      d   = 1'($urandom_range(0, 1));
      rdy = (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      cycle("rand", d, 8'($urandom), rdy, clr);
    end

    // Reset mid-operation with rx_done held high across release
    for (int i = 0; i < DEPTH; i++) cycle("pre_rst_drain", 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) push_byte("pre_rst", 8'(8'hD0 + i), 1'b0);
    chk("pre_rst_level", 32'(bus.level), 32'd5);
    #2;
    rst = 1'b1;
    bus.rx_done = 1'b1;
    bus.rx_data = 8'hC3;
    #1;
    model_reset();
    chk("async_level", 32'(bus.level), 32'd0);
    chk("async_empty", 32'(bus.empty), 32'd1);
    chk("async_valid", 32'(bus.m_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cycle("post_rst_push", 1'b1, 8'hC3, 1'b0, 1'b0);
    cycle("post_rst_hold", 1'b1, 8'hC3, 1'b0, 1'b0);
    cycle("post_rst_lo", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("post_rst_data", 32'(bus.m_data), 32'hC3);
    chk("post_rst_level", 32'(bus.level), 32'd1);
    cycle("post_rst_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("post_rst_end", 1'b0, 8'h00, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer placed directly downstream of the UART receiver FSM.
- Captures each completed byte, flagged by the receiver's rx_done pulse and data_out bus, into a circular FIFO.
- Presents stored bytes to the consumer (CPU bridge or packet parser) on a valid/ready stream interface.
- Reports fill level, overflow and a dropped-byte count.

Parameters:
- DEPTH, 16, number of byte entries; power of 2, minimum 2.
- DATA_W, 8, width of one stored word; matches the receiver data_out width.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- rx_data  input  DATA_W  byte from the receiver; sampled only in the cycle a write is detected.
- rx_done  input  1  receiver completion strobe; may stay high for 1 or more consecutive cycles per byte.
- m_data  output  DATA_W  head-of-FIFO byte; forced to 0 when empty.
- m_valid  output  1  FIFO non-empty.
- m_ready  input  1  consumer accepts m_data.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- empty  output  1  level==0.
- full  output  1  level==DEPTH.
- overflow  output  1  sticky: at least one byte dropped since reset or last clear.
- drop_count  output  CNT_W  dropped bytes; saturates at 2^CNT_W-1.
- overflow_clr  input  1  single-cycle clear of overflow and drop_count.

Behaviour:
- Reset (async, active-high) forces:
  - rd_ptr=0, wr_ptr=0, level=0, empty=1, full=0, m_valid=0, m_data=0, overflow=0, drop_count=0.
  - rx_done_q=0, where rx_done_q is the registered copy of rx_done.
  - Memory contents are don't-care.
  - Reset mid-stream discards all stored bytes; no partial state survives.
- Write detection:
  - push_req = rx_done & ~rx_done_q. Exactly one write per rising edge, however long rx_done stays high.
  - rx_done already high when reset releases counts as an edge, so one write occurs on the first clocked cycle.
- Pop: pop = m_valid & m_ready.
- Push acceptance: push = push_req & (~full | pop). A full FIFO with a simultaneous pop accepts the new byte.
- Drop: push_req & full & ~pop → byte discarded, overflow<=1, drop_count increments (saturating).
- Cycle timing (push_req in cycle N):
  - rx_data is written to mem[wr_ptr] at the end of cycle N.
  - wr_ptr advances, modulo DEPTH.
  - m_valid and level reflect the write in cycle N+1.
  - Write-to-visible latency: 1 cycle.
- Read timing:
  - m_data = mem[rd_ptr] combinationally (show-ahead / first-word fall-through), gated to 0 when empty.
  - On pop, rd_ptr advances modulo DEPTH; the next entry appears in cycle N+1.
- Level update:
  - +1 on push only; -1 on pop only; unchanged on push+pop or on neither.
  - Never exceeds DEPTH and never goes below 0.
- Empty + push_req + m_ready: no pop (m_valid=0); the push is stored; m_valid=1 next cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally. full/empty derive from level, not pointer compare.
- m_data must remain stable while m_valid=1 and m_ready=0, including across a concurrent push.
- overflow_clr in a cycle with no drop: overflow<=0, drop_count<=0.
- overflow_clr in the same cycle as a drop: the new event wins. Result is overflow=1, drop_count=1.
- No combinational path from m_ready to m_valid. m_valid depends only on state.

Test Plan:
- Single byte: reset, rx_data=0xA5 with rx_done high 1 cycle → next cycle m_valid=1, m_data=0xA5, level=1. Assert m_ready 1 cycle → empty=1, m_data=0.
- Long strobe: rx_done high 3 cycles with rx_data=0x3C → level=1 exactly. A second rising edge with 0x5A → level=2, output order 0x3C then 0x5A.
- Fill + overflow (DEPTH=16, m_ready=0): push 0x00..0x0F → full=1, level=16. Push 0x10 and 0x11 → overflow=1, drop_count=2, level=16. Drain → bytes 0x00..0x0F in order, 0x10 and 0x11 never appear.
- Full with simultaneous push+pop: push 0x77 in the same cycle m_ready=1 → level stays 16, no drop. After draining, 0x77 is the last byte out. Pointer wrap is exercised.
- Clear priority: overflow_clr with no drop → overflow=0, drop_count=0. overflow_clr in the same cycle as a dropped push → overflow=1, drop_count=1. Hold 300 drops → drop_count=255.
- Reset mid-operation: with level=5, assert rst asynchronously between edges → level=0, empty=1, m_valid=0 immediately. After release, a new byte 0xC3 is read back alone.
